store_sequencer: RTL and testbench

- Hardware control sequencer that drives the datapath control strobes for the store instruction `st Ra, C(Rb)`, i.e. memory ← R[Ra] at address R[Rb]+C.
- It is the write-direction counterpart of the existing load control sequence: fetch, decode, effective-address compute, then MDR load from the register file and memory write.
- Sits between the datapath control inputs and the memory Read/Write pins.
- Replaces hand-driven bench strobes for `st`.

---
 rtl/store_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_store_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_sequencer.sv
// Control sequencer for `st Ra, C(Rb)`: fetch, decode, address, MDR load, write.
// Optional StoreCount output enabled by defining STORE_SEQ_PERF_EN.
module store_sequencer #(
    parameter logic [4:0]  ST_OPCODE = 5'b00010,
    parameter int unsigned MEM_WAIT  = 1
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Start,
    input  logic [31:0] IRregister,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Grb,
    output logic        BAout,
    output logic        Yin,
    output logic        Cout,
    output logic        ZLOout,
    output logic        Gra,
    output logic        Rout,
    output logic        Write,
    output logic        AluAdd,
    output logic        Busy,
    output logic        Done,
    output logic        Fault
`ifdef STORE_SEQ_PERF_EN
    ,
    output logic [15:0] StoreCount
`endif
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_DEC,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_DONE,
        S_FAULT
    } state_t;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic z_in;
        logic pc_in;
        logic rd;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic grb;
        logic ba_out;
        logic y_in;
        logic c_out;
        logic zlo_out;
        logic gra;
        logic r_out;
        logic wr;
        logic alu_add;
        logic busy;
        logic done;
        logic fault;
    } ctl_t;

    localparam logic [2:0] LP_WAIT = 3'(MEM_WAIT);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_wcnt;
    logic [2:0] w_wcnt_next;
    logic       w_wait_last;
    logic       w_is_st;
    ctl_t       r_ctl;
    ctl_t       w_ctl;
    logic [26:0] w_unused_ir;

    assign w_unused_ir = IRregister[26:0];
    assign w_wait_last = (r_wcnt == LP_WAIT);
    assign w_is_st     = (IRregister[31:27] == ST_OPCODE);

    always_comb begin
        w_next = S_IDLE;
        unique case (r_state)
            S_IDLE:  w_next = Start ? S_T0 : S_IDLE;
            S_T0:    w_next = S_T1;
            S_T1:    w_next = w_wait_last ? S_T2 : S_T1;
            S_T2:    w_next = S_DEC;
            S_DEC:   w_next = w_is_st ? S_T3 : S_FAULT;
            S_T3:    w_next = S_T4;
            S_T4:    w_next = S_T5;
            S_T5:    w_next = S_T6;
            S_T6:    w_next = S_T7;
            S_T7:    w_next = w_wait_last ? S_DONE : S_T7;
            S_DONE:  w_next = S_IDLE;
            S_FAULT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Wait counter only advances while a memory access is still pending.
    always_comb begin
        w_wcnt_next = 3'd0;
        if ((r_state == S_T1 || r_state == S_T7) && !w_wait_last) begin
            w_wcnt_next = r_wcnt + 3'd1;
        end
    end

    // Strobes are decoded from the next state so the registers hold them
    // for exactly the cycles that state is occupied.
    always_comb begin
        w_ctl      = '0;
        w_ctl.busy = (w_next != S_IDLE);
        unique case (w_next)
            S_T0: begin
                w_ctl.pc_out = 1'b1;
                w_ctl.mar_in = 1'b1;
                w_ctl.inc_pc = 1'b1;
                w_ctl.z_in   = 1'b1;
            end
            S_T1: begin
                w_ctl.zlo_out = 1'b1;
                w_ctl.pc_in   = 1'b1;
                w_ctl.rd      = 1'b1;
                w_ctl.mdr_in  = (w_wcnt_next == LP_WAIT);
            end
            S_T2: begin
                w_ctl.mdr_out = 1'b1;
                w_ctl.ir_in   = 1'b1;
            end
            S_T3: begin
                w_ctl.grb    = 1'b1;
                w_ctl.ba_out = 1'b1;
                w_ctl.y_in   = 1'b1;
            end
            S_T4: begin
                w_ctl.c_out   = 1'b1;
                w_ctl.alu_add = 1'b1;
                w_ctl.z_in    = 1'b1;
            end
            S_T5: begin
                w_ctl.zlo_out = 1'b1;
                w_ctl.mar_in  = 1'b1;
            end
            S_T6: begin
                w_ctl.gra    = 1'b1;
                w_ctl.r_out  = 1'b1;
                w_ctl.mdr_in = 1'b1;
            end
            S_T7:    w_ctl.wr    = 1'b1;
            S_DONE:  w_ctl.done  = 1'b1;
            S_FAULT: w_ctl.fault = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_state <= S_IDLE;
            r_wcnt  <= 3'd0;
            r_ctl   <= '0;
        end else begin
            r_state <= w_next;
            r_wcnt  <= w_wcnt_next;
            r_ctl   <= w_ctl;
        end
    end

    assign PCout  = r_ctl.pc_out;
    assign MARin  = r_ctl.mar_in;
    assign IncPC  = r_ctl.inc_pc;
    assign Zin    = r_ctl.z_in;
    assign PCin   = r_ctl.pc_in;
    assign Read   = r_ctl.rd;
    assign MDRin  = r_ctl.mdr_in;
    assign MDRout = r_ctl.mdr_out;
    assign IRin   = r_ctl.ir_in;
    assign Grb    = r_ctl.grb;
    assign BAout  = r_ctl.ba_out;
    assign Yin    = r_ctl.y_in;
    assign Cout   = r_ctl.c_out;
    assign ZLOout = r_ctl.zlo_out;
    assign Gra    = r_ctl.gra;
    assign Rout   = r_ctl.r_out;
    assign Write  = r_ctl.wr;
    assign AluAdd = r_ctl.alu_add;
    assign Busy   = r_ctl.busy;
    assign Done   = r_ctl.done;
    assign Fault  = r_ctl.fault;

`ifdef STORE_SEQ_PERF_EN
    logic [15:0] r_store_count;

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_store_count <= 16'd0;
        end else if (w_next == S_DONE && r_store_count != 16'hFFFF) begin
            r_store_count <= r_store_count + 16'd1;
        end
    end

    assign StoreCount = r_store_count;
`endif

endmodule

// File: tb/tb_store_sequencer.sv
// Bench for store_sequencer: three wait settings side by side against
// a per-instruction strobe-sequence model.
module tb_store_sequencer;

    localparam int N = 3;
    localparam logic [4:0] ST = 5'b00010;

    localparam int B_PCOUT  = 0;
    localparam int B_MARIN  = 1;
    localparam int B_INCPC  = 2;
    localparam int B_ZIN    = 3;
    localparam int B_PCIN   = 4;
    localparam int B_READ   = 5;
    localparam int B_MDRIN  = 6;
    localparam int B_MDROUT = 7;
    localparam int B_IRIN   = 8;
    localparam int B_GRB    = 9;
    localparam int B_BAOUT  = 10;
    localparam int B_YIN    = 11;
    localparam int B_COUT   = 12;
    localparam int B_ZLOOUT = 13;
    localparam int B_GRA    = 14;
    localparam int B_ROUT   = 15;
    localparam int B_WRITE  = 16;
    localparam int B_ALUADD = 17;
    localparam int B_DONE   = 18;
    localparam int B_FAULT  = 19;
    localparam int B_BUSY   = 20;

    localparam logic [20:0] BSY = 21'd1 << B_BUSY;
    localparam logic [20:0] V_T0 = BSY | (21'd1 << B_PCOUT) | (21'd1 << B_MARIN)
                                 | (21'd1 << B_INCPC) | (21'd1 << B_ZIN);
    localparam logic [20:0] V_T1 = BSY | (21'd1 << B_ZLOOUT) | (21'd1 << B_PCIN)
                                 | (21'd1 << B_READ);
    localparam logic [20:0] V_T2 = BSY | (21'd1 << B_MDROUT) | (21'd1 << B_IRIN);
    localparam logic [20:0] V_T3 = BSY | (21'd1 << B_GRB) | (21'd1 << B_BAOUT)
                                 | (21'd1 << B_YIN);
    localparam logic [20:0] V_T4 = BSY | (21'd1 << B_COUT) | (21'd1 << B_ALUADD)
                                 | (21'd1 << B_ZIN);
    localparam logic [20:0] V_T5 = BSY | (21'd1 << B_ZLOOUT) | (21'd1 << B_MARIN);
    localparam logic [20:0] V_T6 = BSY | (21'd1 << B_GRA) | (21'd1 << B_ROUT)
                                 | (21'd1 << B_MDRIN);
    localparam logic [20:0] V_T7 = BSY | (21'd1 << B_WRITE);
    localparam logic [20:0] DRV  = (21'd1 << B_PCOUT) | (21'd1 << B_ZLOOUT)
                                 | (21'd1 << B_MDROUT) | (21'd1 << B_BAOUT)
                                 | (21'd1 << B_COUT) | (21'd1 << B_ROUT);

    logic        Clock = 1'b0;
    logic        Clear;
    logic        Start;
    logic [31:0] IR;
    logic [20:0] obs [N];

    int n_vec = 0;
    int n_err = 0;

    int          mw_of [N] = '{0, 1, 3};
    logic [20:0] seq   [N][32];
    int          len   [N];
    int          ptr   [N];
    bit          idle  [N];
    logic [20:0] exp_v [N];

`ifdef STORE_SEQ_PERF_EN
    logic [15:0] cnt     [N];
    logic [15:0] exp_cnt [N];
`endif

    always #5 Clock = ~Clock;

    for (genvar g = 0; g < N; g++) begin : gen_dut
        localparam int MW = (g == 0) ? 0 : (g == 1) ? 1 : 3;
        logic [20:0] v;
        store_sequencer #(.ST_OPCODE(5'b00010), .MEM_WAIT(MW)) u_dut (
            .Clock(Clock), .Clear(Clear), .Start(Start), .IRregister(IR),
            .PCout(v[B_PCOUT]), .MARin(v[B_MARIN]), .IncPC(v[B_INCPC]),
            .Zin(v[B_ZIN]), .PCin(v[B_PCIN]), .Read(v[B_READ]),
            .MDRin(v[B_MDRIN]), .MDRout(v[B_MDROUT]), .IRin(v[B_IRIN]),
            .Grb(v[B_GRB]), .BAout(v[B_BAOUT]), .Yin(v[B_YIN]),
            .Cout(v[B_COUT]), .ZLOout(v[B_ZLOOUT]), .Gra(v[B_GRA]),
            .Rout(v[B_ROUT]), .Write(v[B_WRITE]), .AluAdd(v[B_ALUADD]),
            .Busy(v[B_BUSY]), .Done(v[B_DONE]), .Fault(v[B_FAULT])
`ifdef STORE_SEQ_PERF_EN
            , .StoreCount(cnt[g])
`endif
        );
        assign obs[g] = v;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic void push(input int i, input logic [20:0] v);
        seq[i][len[i]] = v;
        len[i]++;
    endfunction

    // Whole instruction as a list of per-cycle strobe sets.
    function automatic void build(input int i, input bit is_st);
        len[i] = 0;
        push(i, V_T0);
        for (int w = 0; w <= mw_of[i]; w++)
            push(i, V_T1 | ((w == mw_of[i]) ? (21'd1 << B_MDRIN) : 21'd0));
        push(i, V_T2);
        push(i, BSY);
        if (is_st) begin
            push(i, V_T3);
            push(i, V_T4);
            push(i, V_T5);
            push(i, V_T6);
            for (int w = 0; w <= mw_of[i]; w++) push(i, V_T7);
            push(i, BSY | (21'd1 << B_DONE));
        end else begin
            push(i, BSY | (21'd1 << B_FAULT));
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            idle[i]  = 1'b1;
            len[i]   = 0;
            ptr[i]   = 0;
            exp_v[i] = '0;
`ifdef STORE_SEQ_PERF_EN
            exp_cnt[i] = 16'd0;
`endif
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            if (idle[i]) begin
                if (Start) begin
                    build(i, IR[31:27] == ST);
                    exp_v[i] = seq[i][0];
                    ptr[i]   = 1;
                    idle[i]  = 1'b0;
                end
            end else if (ptr[i] < len[i]) begin
                exp_v[i] = seq[i][ptr[i]];
                ptr[i]++;
            end else begin
                exp_v[i] = '0;
                idle[i]  = 1'b1;
            end
`ifdef STORE_SEQ_PERF_EN
            if (exp_v[i][B_DONE] && exp_cnt[i] != 16'hFFFF) exp_cnt[i]++;
`endif
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            check($sformatf("strobes[mw=%0d]", mw_of[i]), 32'(obs[i]), 32'(exp_v[i]));
            check($sformatf("rd_wr_excl[mw=%0d]", mw_of[i]),
                  32'(obs[i][B_READ] & obs[i][B_WRITE]), 32'd0);
            check($sformatf("bus_drivers[mw=%0d]", mw_of[i]),
                  32'($countones(obs[i] & DRV) > 1), 32'd0);
`ifdef STORE_SEQ_PERF_EN
            check($sformatf("store_count[mw=%0d]", mw_of[i]), 32'(cnt[i]), 32'(exp_cnt[i]));
`endif
        end
    endtask

    task automatic step(input logic st, input logic clr);
        @(negedge Clock);
        Start = st;
        Clear = clr;
        if (clr) model_reset();
        @(posedge Clock);
        if (!Clear) model_edge();
        #1;
        compare_all();
    endtask

    task automatic run_one(input logic [4:0] op);
        int first [N];
        int rd [N];
        int wr [N];
        int bz [N];
        int dn [N];
        int ft [N];
        for (int i = 0; i < N; i++) begin
            first[i] = 0; rd[i] = 0; wr[i] = 0; bz[i] = 0; dn[i] = 0; ft[i] = 0;
        end
        IR = {op, 27'($urandom)};
        step(1'b0, 1'b0);
        for (int n = 1; n <= 30; n++) begin
            step(n == 1, 1'b0);
            for (int i = 0; i < N; i++) begin
                if (obs[i][B_DONE] && first[i] == 0) first[i] = n;
                rd[i] += int'(obs[i][B_READ]);
                wr[i] += int'(obs[i][B_WRITE]);
                bz[i] += int'(obs[i][B_BUSY]);
                dn[i] += int'(obs[i][B_DONE]);
                ft[i] += int'(obs[i][B_FAULT]);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (op == ST) begin
                check($sformatf("done_latency[mw=%0d]", mw_of[i]), first[i], 10 + 2 * mw_of[i]);
                check($sformatf("read_cycles[mw=%0d]", mw_of[i]), rd[i], mw_of[i] + 1);
                check($sformatf("write_cycles[mw=%0d]", mw_of[i]), wr[i], mw_of[i] + 1);
                check($sformatf("busy_cycles[mw=%0d]", mw_of[i]), bz[i], 10 + 2 * mw_of[i]);
                check($sformatf("done_pulses[mw=%0d]", mw_of[i]), dn[i], 1);
            end else begin
                check($sformatf("fault_busy[mw=%0d]", mw_of[i]), bz[i], 5 + mw_of[i]);
                check($sformatf("fault_write[mw=%0d]", mw_of[i]), wr[i], 0);
                check($sformatf("fault_done[mw=%0d]", mw_of[i]), dn[i], 0);
                check($sformatf("fault_pulses[mw=%0d]", mw_of[i]), ft[i], 1);
            end
        end
    endtask

    initial begin
        bit found;
        Clear = 1'b1;
        Start = 1'b0;
        IR    = '0;
        model_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        run_one(ST);
        run_one(5'b00000);

        // Clear during the second write cycle of the slowest instance.
        IR = {ST, 27'h0000045};
        step(1'b1, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            step(1'b0, 1'b0);
            if (obs[2][B_WRITE]) found = 1'b1;
        end
        check("t7_reached", 32'(found), 32'd1);
        @(posedge Clock);
        model_edge();
        #1;
        compare_all();
        #2;
        Clear = 1'b1;
        model_reset();
        #1;
        check("clear_write", 32'(obs[2][B_WRITE]), 32'd0);
        check("clear_busy", 32'(obs[2][B_BUSY]), 32'd0);
        compare_all();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        run_one(ST);

        // Start pulsed mid-sequence, then held across DONE.
        IR = {ST, 27'h1};
        step(1'b1, 1'b0);
        for (int n = 2; n <= 45; n++) step((n == 8) || (n >= 12 && n <= 30), 1'b0);
        for (int n = 0; n < 20; n++) step(1'b0, 1'b0);

`ifdef STORE_SEQ_PERF_EN
        @(negedge Clock);
        force gen_dut[0].u_dut.r_store_count = 16'hFFFE;
        force gen_dut[1].u_dut.r_store_count = 16'hFFFE;
        force gen_dut[2].u_dut.r_store_count = 16'hFFFE;
        #1;
        release gen_dut[0].u_dut.r_store_count;
        release gen_dut[1].u_dut.r_store_count;
        release gen_dut[2].u_dut.r_store_count;
        for (int i = 0; i < N; i++) exp_cnt[i] = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            run_one(ST);
            for (int i = 0; i < N; i++)
                check($sformatf("sat_count[mw=%0d]", mw_of[i]), 32'(cnt[i]), 32'hFFFF);
        end
`endif

        for (int c = 0; c < 800; c++) begin
            if (idle[0] && idle[1] && idle[2] && $urandom_range(0, 3) == 0)
                IR = {(($urandom_range(0, 9) < 7) ? ST : 5'($urandom)), 27'($urandom)};
            step($urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
        end
        for (int n = 0; n < 20; n++) step(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
